// File: rtl/conv_window_fetch_pkg.sv
// Shared definitions for the 3x3 window fetcher: FSM state encodings,
// kernel geometry constants and a small tap-position helper.
package conv_window_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } fetch_state_e;

    localparam int KERNEL_TAPS = 9;
    localparam int KERNEL_DIM  = 3;

    localparam logic [1:0] KDIM_LAST = 2'(KERNEL_DIM - 1);

    // True on the bottom-right tap of the kernel.
    function automatic logic tap_is_last(input logic [1:0] kr, input logic [1:0] kc);
        return (kr == KDIM_LAST) && (kc == KDIM_LAST);
    endfunction

endpackage

// File: rtl/conv_window_fetch_addr_gen.sv
// Window/tap counters and the incremental BRAM read address for the 3x3 scan.
// The address is only ever stepped by small constants, never multiplied.
module conv_window_fetch_addr_gen
    import conv_window_fetch_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       row,
    output logic [15:0]       col,
    output logic              last_tap,
    output logic              last_win
);

    localparam logic [15:0]       COL_LAST      = 16'(IMG_W - 3);
    localparam logic [15:0]       ROW_LAST      = 16'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] KC_WRAP_STEP  = ADDR_W'(IMG_W - 2);
    // Last column to the next row's first window: skip the two right-hand margin pixels.
    localparam logic [ADDR_W-1:0] ROW_WRAP_STEP = ADDR_W'(KERNEL_DIM);

    logic [1:0]        kr_r, kc_r, kr_s, kc_s;
    logic [15:0]       row_r, col_r, row_s, col_s;
    logic [ADDR_W-1:0] addr_r, base_r, addr_s, base_s;
    logic              last_tap_s, col_last_s, last_win_s;

    assign last_tap_s = tap_is_last(kr_r, kc_r);
    assign col_last_s = (col_r == COL_LAST);
    assign last_win_s = col_last_s && (row_r == ROW_LAST);

    // Next counter/address values for a tap step or a window advance.
    always_comb begin
        kr_s   = kr_r;
        kc_s   = kc_r;
        row_s  = row_r;
        col_s  = col_r;
        addr_s = addr_r;
        base_s = base_r;
        if (advance) begin
            kr_s = 2'd0;
            kc_s = 2'd0;
            if (last_win_s) begin
                row_s  = 16'd0;
                col_s  = 16'd0;
                base_s = {ADDR_W{1'b0}};
            end else if (col_last_s) begin
                row_s  = row_r + 16'd1;
                col_s  = 16'd0;
                base_s = base_r + ROW_WRAP_STEP;
            end else begin
                col_s  = col_r + 16'd1;
                base_s = base_r + ADDR_ONE;
            end
            addr_s = base_s;
        end else if (step) begin
            if (last_tap_s) begin
                kr_s   = 2'd0;
                kc_s   = 2'd0;
                addr_s = base_r;
            end else if (kc_r == KDIM_LAST) begin
                kr_s   = kr_r + 2'd1;
                kc_s   = 2'd0;
                addr_s = addr_r + KC_WRAP_STEP;
            end else begin
                kc_s   = kc_r + 2'd1;
                addr_s = addr_r + ADDR_ONE;
            end
        end else begin
            addr_s = addr_r;
        end
    end

    // Counter and address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            kr_r   <= 2'd0;
            kc_r   <= 2'd0;
            row_r  <= 16'd0;
            col_r  <= 16'd0;
            addr_r <= {ADDR_W{1'b0}};
            base_r <= {ADDR_W{1'b0}};
        end else begin
            kr_r   <= kr_s;
            kc_r   <= kc_s;
            row_r  <= row_s;
            col_r  <= col_s;
            addr_r <= addr_s;
            base_r <= base_s;
        end
    end

    assign addr     = addr_r;
    assign row      = row_r;
    assign col      = col_r;
    assign last_tap = last_tap_s;
    assign last_win = last_win_s;

endmodule

// File: rtl/conv_window_fetch.sv
// Reads each 3x3 window of a row-major image from BRAM, streams the bytes
// to the window shift register and holds win_ready until the conv core acks.
module conv_window_fetch
    import conv_window_fetch_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              win_ready,
    input  logic              conv_ack,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col,
    output logic              busy,
    output logic              frame_done
);

    fetch_state_e state_r, state_s;
    logic         step_s, advance_s, last_tap_s, last_win_s;
    logic         bram_en_s, win_ready_s, busy_s, frame_done_s;
    logic         bram_en_r, win_ready_r, busy_r, frame_done_r, pix_valid_r;

    assign step_s    = (state_r == ST_FETCH);
    assign advance_s = (state_r == ST_WAIT_ACK) && conv_ack;

    conv_window_fetch_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .step     (step_s),
        .advance  (advance_s),
        .addr     (bram_addr),
        .row      (out_row),
        .col      (out_col),
        .last_tap (last_tap_s),
        .last_win (last_win_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:     state_s = start ? ST_FETCH : ST_IDLE;
            ST_FETCH:    state_s = last_tap_s ? ST_DRAIN : ST_FETCH;
            ST_DRAIN:    state_s = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (conv_ack) begin
                    state_s = last_win_s ? ST_DONE : ST_FETCH;
                end else begin
                    state_s = ST_WAIT_ACK;
                end
            end
            ST_DONE:     state_s = ST_IDLE;
            default:     state_s = ST_IDLE;
        endcase
    end

    // FSM output decode from the next state, so the flops below line up with the state.
    always_comb begin
        bram_en_s    = 1'b0;
        win_ready_s  = 1'b0;
        frame_done_s = 1'b0;
        busy_s       = 1'b1;
        case (state_s)
            ST_IDLE:     busy_s       = 1'b0;
            ST_FETCH:    bram_en_s    = 1'b1;
            ST_DRAIN:    busy_s       = 1'b1;
            ST_WAIT_ACK: win_ready_s  = 1'b1;
            ST_DONE:     frame_done_s = 1'b1;
            default:     busy_s       = 1'b0;
        endcase
    end

    // Output and data-path delay registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_en_r    <= 1'b0;
            win_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            pix_valid_r  <= 1'b0;
        end else begin
            bram_en_r    <= bram_en_s;
            win_ready_r  <= win_ready_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
            pix_valid_r  <= bram_en_r;
        end
    end

    // The BRAM output register already carries the one-clock read delay; gating keeps idle bytes at zero.
    assign pix_data   = pix_valid_r ? bram_dout : {DATA_W{1'b0}};
    assign pix_valid  = pix_valid_r;
    assign bram_en    = bram_en_r;
    assign win_ready  = win_ready_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed bench: 4x4 image (mem[a]=a) for framing, backpressure, reset and
// start-while-busy, plus a 7x5 image for scan wrap and window count.
module tb_conv_window_fetch;
    import conv_window_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, conv_ack, mon_clear;
    logic [7:0]  bram_addr, pix_data;
    logic [7:0]  bram_dout = 8'd0;
    logic        bram_en, pix_valid, win_ready, busy, frame_done;
    logic [15:0] out_row, out_col;

    logic        start_b, ack_b;
    logic [7:0]  bram_addr_b, pix_data_b;
    logic [7:0]  bram_dout_b = 8'd0;
    logic        bram_en_b, pix_valid_b, win_ready_b, busy_b, frame_done_b;
    logic [15:0] out_row_b, out_col_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_window_fetch #(.IMG_W(4), .IMG_H(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .bram_addr(bram_addr), .bram_en(bram_en),
        .bram_dout(bram_dout), .pix_data(pix_data), .pix_valid(pix_valid),
        .win_ready(win_ready), .conv_ack(conv_ack), .out_row(out_row), .out_col(out_col),
        .busy(busy), .frame_done(frame_done)
    );

    conv_window_fetch #(.IMG_W(7), .IMG_H(5), .ADDR_W(8), .DATA_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bram_addr(bram_addr_b), .bram_en(bram_en_b),
        .bram_dout(bram_dout_b), .pix_data(pix_data_b), .pix_valid(pix_valid_b),
        .win_ready(win_ready_b), .conv_ack(ack_b), .out_row(out_row_b), .out_col(out_col_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    // BRAM models: mem[a] = a, one clock read latency.
    always @(posedge clk) begin
        if (bram_en) bram_dout <= bram_addr;
        if (bram_en_b) bram_dout_b <= bram_addr_b;
    end

    task automatic check_value(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 4x4 instance: collects windows, pulses and timing violations.
    int          nwin, ndone, en_cnt, timing_err, nbytes;
    logic [71:0] sr;
    logic [71:0] win_data [0:7];
    logic [31:0] win_rc   [0:7];
    logic        prev_en, prev_valid, prev_ready;

    initial begin
        nwin = 0; ndone = 0; en_cnt = 0; timing_err = 0; nbytes = 0; sr = '0;
        prev_en = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_clear) begin
                nwin = 0; ndone = 0; en_cnt = 0; timing_err = 0; nbytes = 0; sr = '0;
            end else begin
                if (pix_valid !== prev_en) timing_err++;
                if (pix_valid) begin
                    sr = {pix_data, sr[71:8]};
                    nbytes++;
                end
                if (win_ready && !prev_ready) begin
                    if (nbytes != KERNEL_TAPS || !prev_valid || pix_valid) timing_err++;
                    if (nwin < 8) begin
                        win_data[nwin] = sr;
                        win_rc[nwin]   = {out_row, out_col};
                    end
                    nwin++;
                    nbytes = 0;
                end
                if (frame_done) ndone++;
                if (bram_en) en_cnt++;
            end
            prev_en = bram_en; prev_valid = pix_valid; prev_ready = win_ready;
        end
    end

    // Monitor for the 7x5 instance: window count and the last window seen.
    int          nwin_b;
    logic [71:0] sr_b, last_data_b;
    logic [31:0] last_rc_b;
    logic        prev_ready_b;

    initial begin
        nwin_b = 0; sr_b = '0; last_data_b = '0; last_rc_b = '0; prev_ready_b = 1'b0;
        forever begin
            @(negedge clk);
            if (pix_valid_b) sr_b = {pix_data_b, sr_b[71:8]};
            if (win_ready_b && !prev_ready_b) begin
                nwin_b++;
                last_data_b = sr_b;
                last_rc_b   = {out_row_b, out_col_b};
            end
            prev_ready_b = win_ready_b;
        end
    end

    logic [71:0] exp_data [0:3];
    logic [31:0] exp_rc   [0:3];
    int          cyc, bp_bad;

    initial begin
        // Top-left byte in the LSByte, bottom-right in the MSByte.
        exp_data = '{72'h0a0908060504020100, 72'h0b0a09070605030201,
                     72'h0e0d0c0a0908060504, 72'h0f0e0d0b0a09070605};
        exp_rc   = '{32'h0000_0000, 32'h0000_0001, 32'h0001_0000, 32'h0001_0001};
        rst = 1'b1; start = 1'b0; conv_ack = 1'b0; mon_clear = 1'b1; start_b = 1'b0; ack_b = 1'b1;
        repeat (3) tick();
        check_value("rst_ctrl", {67'd0, bram_en, pix_valid, win_ready, busy, frame_done}, 72'd0);
        check_value("rst_addr_pix", {56'd0, bram_addr, pix_data}, 72'd0);
        check_value("rst_rowcol", {40'd0, out_row, out_col}, 72'd0);
        rst = 1'b0;
        tick();
        mon_clear = 1'b0;

        // Frame 1: ack tied high.
        conv_ack = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check_value("f1_first_en", {71'd0, bram_en}, 72'd1);
        check_value("f1_first_addr", {64'd0, bram_addr}, 72'd0);
        check_value("f1_busy", {71'd0, busy}, 72'd1);
        cyc = 1;
        while (!frame_done && cyc < 300) begin tick(); cyc++; end
        check_value("f1_done_cycle", 72'(cyc), 72'd45);
        repeat (20) tick();
        check_value("f1_nwin", 72'(nwin), 72'd4);
        for (int i = 0; i < 4; i++) begin
            check_value($sformatf("f1_win%0d_data", i), win_data[i], exp_data[i]);
            check_value($sformatf("f1_win%0d_rc", i), {40'd0, win_rc[i]}, {40'd0, exp_rc[i]});
        end
        check_value("f1_done_pulse", 72'(ndone), 72'd1);
        check_value("f1_en_count", 72'(en_cnt), 72'd36);
        check_value("f1_timing", 72'(timing_err), 72'd0);
        check_value("f1_idle", {71'd0, busy}, 72'd0);

        // Frame 2: backpressure on window 1, stray ack during FETCH.
        mon_clear = 1'b1; tick(); mon_clear = 1'b0;
        conv_ack = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); conv_ack = 1'b1; tick(); conv_ack = 1'b0;
        cyc = 0;
        while (!win_ready && cyc < 50) begin tick(); cyc++; end
        check_value("bp_w0_ready", {71'd0, win_ready}, 72'd1);
        check_value("bp_w0_rc", {40'd0, out_row, out_col}, 72'd0);
        conv_ack = 1'b1; tick(); conv_ack = 1'b0;
        cyc = 0;
        while (!win_ready && cyc < 50) begin tick(); cyc++; end
        check_value("bp_w1_ready", {71'd0, win_ready}, 72'd1);
        bp_bad = 0;
        repeat (20) begin
            tick();
            if (!win_ready || bram_en || out_row != 16'd0 || out_col != 16'd1) bp_bad++;
        end
        check_value("bp_hold_stable", 72'(bp_bad), 72'd0);
        conv_ack = 1'b1; tick();
        check_value("bp_release", {70'd0, win_ready, bram_en}, 72'd1);
        check_value("bp_w2_rc", {40'd0, out_row, out_col}, {40'd0, 16'd1, 16'd0});
        check_value("bp_w2_addr", {64'd0, bram_addr}, 72'd4);
        cyc = 0;
        while (!frame_done && cyc < 300) begin tick(); cyc++; end
        repeat (5) tick();
        check_value("bp_nwin", 72'(nwin), 72'd4);
        check_value("bp_w2_data", win_data[2], exp_data[2]);
        check_value("bp_timing", 72'(timing_err), 72'd0);

        // Frame 3: reset after the 4th read.
        mon_clear = 1'b1; tick(); mon_clear = 1'b0;
        conv_ack = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        check_value("mr_4th_en", {64'd0, bram_en, bram_addr[6:0]}, {64'd0, 1'b1, 7'd4});
        rst = 1'b1; mon_clear = 1'b1; tick();
        check_value("mr_ctrl", {67'd0, bram_en, pix_valid, win_ready, busy, frame_done}, 72'd0);
        check_value("mr_addr_pix", {56'd0, bram_addr, pix_data}, 72'd0);
        check_value("mr_rowcol", {40'd0, out_row, out_col}, 72'd0);
        rst = 1'b0; tick(); mon_clear = 1'b0;
        repeat (5) tick();
        check_value("mr_stays_idle", {70'd0, busy, bram_en}, 72'd0);
        start = 1'b1; tick(); start = 1'b0;
        check_value("mr_restart", {63'd0, bram_en, bram_addr}, {63'd0, 1'b1, 8'd0});
        cyc = 0;
        while (!frame_done && cyc < 300) begin tick(); cyc++; end
        repeat (5) tick();
        check_value("mr_nwin", 72'(nwin), 72'd4);
        check_value("mr_w0_data", win_data[0], exp_data[0]);

        // Frame 4: start pulses in WAIT_ACK and DONE are ignored.
        mon_clear = 1'b1; tick(); mon_clear = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!win_ready && cyc < 50) begin tick(); cyc++; end
        start = 1'b1; tick(); start = 1'b0;
        check_value("sb_after_wait", {40'd0, out_row, out_col}, {40'd0, 16'd0, 16'd1});
        cyc = 0;
        while (!frame_done && cyc < 300) begin tick(); cyc++; end
        check_value("sb_done_seen", {71'd0, frame_done}, 72'd1);
        start = 1'b1; tick(); start = 1'b0;
        repeat (30) tick();
        check_value("sb_nwin", 72'(nwin), 72'd4);
        check_value("sb_ndone", 72'(ndone), 72'd1);
        check_value("sb_en_count", 72'(en_cnt), 72'd36);
        check_value("sb_idle", {71'd0, busy}, 72'd0);

        // 7x5 image: 5x3 windows, row wrap, last window at (2,4).
        start_b = 1'b1; tick(); start_b = 1'b0;
        cyc = 1;
        while (!frame_done_b && cyc < 400) begin tick(); cyc++; end
        check_value("b_done_cycle", 72'(cyc), 72'd166);
        repeat (5) tick();
        check_value("b_nwin", 72'(nwin_b), 72'd15);
        check_value("b_last_rc", {40'd0, last_rc_b}, {40'd0, 16'd2, 16'd4});
        check_value("b_last_data", last_data_b, 72'h2221201b1a19141312);
        check_value("b_idle", {71'd0, busy_b}, 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
